ext_pipe: RTL and testbench

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pipe.sv | 161 ++++++++++++++++
 tb/tb_ext_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: immediate extension unit followed by a small in-order result
// buffer with valid/ready handshakes on both sides.
//
// Each accepted beat is extended according to mode. The extended value and an
// error flag are written into a DEPTH-entry circular buffer. The head entry
// drives result/out_err.
//
//   mode | operation
//   0    | ZERO   : imm zero-extended
//   1    | SIGN   : imm sign-extended from bit IN_W-1
//   2    | LUI    : imm placed in the upper IN_W bits, low bits zero
//   3    | BRANCH : sign-extended imm shifted left by 2
//   4    | SEXT8  : imm[7:0] sign-extended
//   5    | ZEXT8  : imm[7:0] zero-extended
//   6,7  | reserved: result 0, out_err 1
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  source presents a beat
//   in_ready  buffer not full
//   imm       immediate operand, IN_W bits
//   mode      extension mode select
//   out_valid head entry valid
//   out_ready sink takes head entry
//   result    extended value at buffer head, OUT_W bits
//   out_err   head beat used a reserved mode
//   flush     synchronous discard of all buffered beats and any same-cycle input
//   acc_cnt   saturating accepted-beat count (only when EXT_PERF_CNT_EN is defined)
//
// Optional feature: define EXT_PERF_CNT_EN to add the acc_cnt port and counter.

module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] result,
   output logic             out_err,
   input  logic             flush
`ifdef EXT_PERF_CNT_EN
   ,
   output logic [15:0]      acc_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   localparam logic [2:0] MODE_ZERO   = 3'd0;
   localparam logic [2:0] MODE_SIGN   = 3'd1;
   localparam logic [2:0] MODE_LUI    = 3'd2;
   localparam logic [2:0] MODE_BRANCH = 3'd3;
   localparam logic [2:0] MODE_SEXT8  = 3'd4;
   localparam logic [2:0] MODE_ZEXT8  = 3'd5;

   logic [OUT_W-1:0] mem_res [DEPTH];
   logic             mem_err [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             accept;
   logic             retire;

   logic [OUT_W-1:0] sext_imm;
   logic [OUT_W-1:0] ext_res;
   logic             ext_err;

   // ---------------------------------------------------------------------
   // Extension datapath
   // ---------------------------------------------------------------------
   assign sext_imm = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      ext_res = '0;
      ext_err = 1'b0;
      case (mode)
         MODE_ZERO:   ext_res = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_SIGN:   ext_res = sext_imm;
         MODE_LUI:    ext_res = {imm, {(OUT_W-IN_W){1'b0}}};
         // Shift drops the top two sign bits; truncation to OUT_W is intended.
         MODE_BRANCH: ext_res = sext_imm << 2;
         MODE_SEXT8:  ext_res = {{(OUT_W-8){imm[7]}}, imm[7:0]};
         MODE_ZEXT8:  ext_res = {{(OUT_W-8){1'b0}}, imm[7:0]};
         default: begin
            ext_res = '0;
            ext_err = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------
   // in_ready depends only on registered occupancy, so a full buffer never
   // accepts even if the head retires in the same cycle.
   assign full      = (count == CNT_FULL);
   assign in_ready  = !full;
   assign out_valid = (count != '0);
   assign accept    = in_valid && in_ready && !flush;
   assign retire    = out_valid && out_ready && !flush;

   assign result    = mem_res[rd_ptr];
   assign out_err   = mem_err[rd_ptr];

   // ---------------------------------------------------------------------
   // Buffer state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_res[i] <= '0;
            mem_err[i] <= 1'b0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            mem_res[wr_ptr] <= ext_res;
            mem_err[wr_ptr] <= ext_err;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (retire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({accept, retire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef EXT_PERF_CNT_EN
   // Counts accepted beats only; flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt <= '0;
      end else if (accept && (acc_cnt != 16'hFFFF)) begin
         acc_cnt <= acc_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             flush = 1'b0;
   logic [IN_W-1:0]  imm = '0;
   logic [2:0]       mode = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_err;
   logic [OUT_W-1:0] result;
`ifdef EXT_PERF_CNT_EN
   logic [15:0]      acc_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int n_acc = 0;
   bit mon_en = 1'b1;
   logic [OUT_W:0] exp_q[$];
   logic [OUT_W:0] exp_head;
   logic [OUT_W-1:0] held;

   ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_err   (out_err),
      .flush     (flush)
`ifdef EXT_PERF_CNT_EN
      ,
      .acc_cnt   (acc_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT retires a beat.
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%h required=none", {out_err, result});
         end else begin
            exp_head = exp_q.pop_front();
            chk("scoreboard", 64'({out_err, result}), 64'(exp_head));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [IN_W-1:0] v, input logic [2:0] m, input logic [OUT_W:0] e);
      int n;
      n = 0;
      in_valid = 1'b1;
      imm = v;
      mode = m;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            n_acc++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            break;
         end
         n++;
         if (n > 50) begin
            chk("send_timeout", 64'(n), 64'(0));
            in_valid = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
      chk("drain_out_valid", 64'(out_valid), 64'(0));
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_out_err", 64'(out_err), 64'(0));
`ifdef EXT_PERF_CNT_EN
      chk("rst_acc_cnt", 64'(acc_cnt), 64'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Sign then zero extension with one-cycle latency
      out_ready = 1'b1;
      send(16'h8001, 3'd1, {1'b0, 32'hFFFF8001});
      chk("latency_sign", 64'(out_valid), 64'(1));
      send(16'h8001, 3'd0, {1'b0, 32'h00008001});
      chk("latency_zero", 64'(out_valid), 64'(1));

      // Mode table
      send(16'h1234, 3'd2, {1'b0, 32'h12340000});
      send(16'hFFFF, 3'd3, {1'b0, 32'hFFFFFFFC});
      send(16'h0080, 3'd4, {1'b0, 32'hFFFFFF80});
      send(16'h0080, 3'd6, {1'b1, 32'h00000000});
      send(16'h0080, 3'd5, {1'b0, 32'h00000080});
      send(16'hABCD, 3'd7, {1'b1, 32'h00000000});
      send(16'h7FFF, 3'd1, {1'b0, 32'h00007FFF});
      send(16'h127F, 3'd4, {1'b0, 32'h0000007F});
      send(16'h2000, 3'd3, {1'b0, 32'h00008000});
      send(16'h8000, 3'd3, {1'b0, 32'hFFFE0000});
      send(16'hFFFF, 3'd2, {1'b0, 32'hFFFF0000});
      send(16'hFFFF, 3'd0, {1'b0, 32'h0000FFFF});
      drain();

      // Backpressure: A,B fill the buffer, C waits
      out_ready = 1'b0;
      send(16'h000A, 3'd0, {1'b0, 32'h0000000A});
      send(16'h000B, 3'd0, {1'b0, 32'h0000000B});
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_out_valid", 64'(out_valid), 64'(1));
      held = result;
      chk("head_is_a", 64'(held), 64'(32'h0000000A));
      repeat (3) @(posedge clk);
      #1;
      chk("hold_result", 64'(result), 64'(32'h0000000A));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      send(16'h000C, 3'd0, {1'b0, 32'h0000000C});
      drain();

      // Flush while full with a beat offered
      out_ready = 1'b0;
      send(16'h1111, 3'd0, {1'b0, 32'h00001111});
      send(16'h2222, 3'd0, {1'b0, 32'h00002222});
`ifdef EXT_PERF_CNT_EN
      chk("acc_before_flush", 64'(acc_cnt), 64'(n_acc));
`endif
      flush = 1'b1;
      in_valid = 1'b1;
      imm = 16'h5555;
      mode = 3'd0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
`ifdef EXT_PERF_CNT_EN
      chk("acc_after_flush", 64'(acc_cnt), 64'(n_acc));
`endif
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_still_empty", 64'(out_valid), 64'(0));
      send(16'h0F0F, 3'd1, {1'b0, 32'h00000F0F});
      drain();

      // Asynchronous reset with two beats buffered
      out_ready = 1'b0;
      send(16'h3333, 3'd0, {1'b0, 32'h00003333});
      send(16'h4444, 3'd0, {1'b0, 32'h00004444});
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'(0));
      chk("arst_in_ready", 64'(in_ready), 64'(1));
      chk("arst_result", 64'(result), 64'(0));
      chk("arst_out_err", 64'(out_err), 64'(0));
`ifdef EXT_PERF_CNT_EN
      chk("arst_acc_cnt", 64'(acc_cnt), 64'(0));
`endif
      exp_q.delete();
      n_acc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", 64'(out_valid), 64'(0));
      send(16'hFF80, 3'd5, {1'b0, 32'h00000080});
      drain();
`ifdef EXT_PERF_CNT_EN
      chk("acc_after_rst", 64'(acc_cnt), 64'(n_acc));

      // Saturation: 70000 back-to-back accepts
      mon_en = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      imm = 16'h0001;
      mode = 3'd0;
      repeat (70000) @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
      chk("acc_saturate", 64'(acc_cnt), 64'(16'hFFFF));
      send(16'h0002, 3'd0, {1'b0, 32'h00000002});
      chk("acc_hold_sat", 64'(acc_cnt), 64'(16'hFFFF));
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
